// File: rtl/mc_datapath_p.sv
// Multi-cycle MIPS-subset datapath: PC, IR, MDR, A/B, ALUOut, regfile and ALU; MCDP_OVF_TRAP_EN adds an overflow trap with EPC.
// Latency: state updates on each enabled rising edge; zero/overflow/M_addr are combinational from current state and controls.
// Backpressure: MIO_ready=0 freezes every state element, including the regfile; reset still wins.
module mc_datapath_p #(
    parameter int                DATA_W   = 32,
    parameter int                REG_AW   = 5,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter logic [DATA_W-1:0] TRAP_VEC = 'h80
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MIO_ready,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic [1:0]        RegDst,
    input  logic              RegWrite,
    input  logic [1:0]        MemtoReg,
    input  logic              ALUSrcA,
    input  logic [1:0]        ALUSrcB,
    input  logic [1:0]        PCSource,
    input  logic              PCWrite,
    input  logic              PCWriteCond,
    input  logic              Branch,
    input  logic              BranchNE,
    input  logic              OvfChk,
    input  logic [2:0]        ALU_operation,
    input  logic [DATA_W-1:0] data2CPU,
    output logic [DATA_W-1:0] PC_Current,
    output logic [DATA_W-1:0] M_addr,
    output logic [31:0]       Inst,
    output logic [DATA_W-1:0] data_out,
    output logic              zero,
    output logic              overflow,
    output logic              trap
);

    localparam int NREG = 1 << REG_AW;
    localparam int SHW  = (DATA_W == 64) ? 6 : 5;

    logic [DATA_W-1:0] pc, mdr, a_lat, b_lat, alu_out;
    logic [31:0]       ir;
    logic [DATA_W-1:0] regs [NREG];

    logic [REG_AW-1:0] rs_idx, rt_idx, rd_idx, wr_idx;
    logic [DATA_W-1:0] rs_dat, rt_dat, wr_dat;
    logic [DATA_W-1:0] imm_sext, lui_val, jump_addr, pc_next;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res, add_sum, sub_dif;
    logic              pc_ld, trap_fire;

    assign rs_idx = ir[21 +: REG_AW];
    assign rt_idx = ir[16 +: REG_AW];
    assign rd_idx = ir[11 +: REG_AW];
    assign rs_dat = (rs_idx == '0) ? '0 : regs[rs_idx];
    assign rt_dat = (rt_idx == '0) ? '0 : regs[rt_idx];

    assign imm_sext = DATA_W'($signed(ir[15:0]));
    assign lui_val  = DATA_W'($signed({ir[15:0], 16'b0}));

    always_comb begin
        jump_addr       = pc;
        jump_addr[27:0] = {ir[25:0], 2'b00};
    end

    assign alu_a   = ALUSrcA ? a_lat : pc;
    assign add_sum = alu_a + alu_b;
    assign sub_dif = alu_a - alu_b;

    always_comb begin
        alu_b = b_lat;
        case (ALUSrcB)
            2'd0:    alu_b = b_lat;
            2'd1:    alu_b = DATA_W'(4);
            2'd2:    alu_b = imm_sext;
            default: alu_b = imm_sext << 2;
        endcase
    end

    always_comb begin
        alu_res  = '0;
        overflow = 1'b0;
        case (ALU_operation)
            3'b000: alu_res = alu_a & alu_b;
            3'b001: alu_res = alu_a | alu_b;
            3'b010: begin
                alu_res  = add_sum;
                overflow = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                           (add_sum[DATA_W-1] != alu_a[DATA_W-1]);
            end
            3'b110: begin
                alu_res  = sub_dif;
                overflow = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                           (sub_dif[DATA_W-1] != alu_a[DATA_W-1]);
            end
            3'b111:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            3'b100:  alu_res = ~(alu_a | alu_b);
            3'b101:  alu_res = alu_b >> alu_a[SHW-1:0];
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    assign zero = (alu_res == '0);

    always_comb begin
        pc_next = alu_res;
        case (PCSource)
            2'd0:    pc_next = alu_res;
            2'd1:    pc_next = alu_out;
            2'd2:    pc_next = jump_addr;
            default: pc_next = a_lat;
        endcase
    end

    assign pc_ld = PCWrite | (PCWriteCond & Branch & (zero ^ BranchNE));

    // RegDst=3 is treated like rt so the write address is always defined.
    always_comb begin
        wr_idx = rt_idx;
        case (RegDst)
            2'd1:    wr_idx = rd_idx;
            2'd2:    wr_idx = '1;
            default: wr_idx = rt_idx;
        endcase
    end

    always_comb begin
        wr_dat = alu_out;
        case (MemtoReg)
            2'd0:    wr_dat = alu_out;
            2'd1:    wr_dat = mdr;
            2'd2:    wr_dat = lui_val;
            default: wr_dat = pc;
        endcase
    end

`ifdef MCDP_OVF_TRAP_EN
    logic [DATA_W-1:0] epc;
    logic              trap_q;

    assign trap_fire = OvfChk & overflow & RegWrite;
    assign trap      = trap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            epc    <= '0;
            trap_q <= 1'b0;
        end else begin
            trap_q <= MIO_ready & trap_fire;
            if (MIO_ready && trap_fire)
                epc <= pc - DATA_W'(4);
        end
    end
`else
    wire unused_ovf_chk = OvfChk;

    assign trap_fire = 1'b0;
    assign trap      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= PC_RESET;
            ir      <= '0;
            mdr     <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            alu_out <= '0;
        end else if (MIO_ready) begin
            mdr     <= data2CPU;
            a_lat   <= rs_dat;
            b_lat   <= rt_dat;
            alu_out <= alu_res;
            if (IRWrite)
                ir <= data2CPU[31:0];
            if (trap_fire)
                pc <= TRAP_VEC;
            else if (pc_ld)
                pc <= pc_next;
        end
    end

    // No write bypass: a same-cycle read sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (MIO_ready && RegWrite && !trap_fire && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_dat;
        end
    end

    assign PC_Current = pc;
    assign M_addr     = IorD ? alu_out : pc;
    assign Inst       = ir;
    assign data_out   = b_lat;

endmodule
